multdiv_ctrl: RTL
=================

# multdiv_ctrl

Sequential controller and iterative datapath that replaces the single-cycle multiplier with a multi-cycle signed multiply/divide unit. It accepts one-cycle start pulses from the execute stage, latches the operands and runs a 32-iteration shift-add multiply or restoring divide. It then presents the result with an exception flag and a one-cycle ready strobe. The processor's stall logic uses `busy` to hold the pipeline while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width. Only 32 is supported. Iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ctrl_MULT`  in  1  start signed multiply; one-cycle pulse
- `ctrl_DIV`  in  1  start signed divide; one-cycle pulse
- `data_operandA`  in  32  multiplicand / dividend; sampled only on an accepted start
- `data_operandB`  in  32  multiplier / divisor; sampled only on an accepted start
- `data_result`  out  32  registered result; holds until the next completion
- `data_exception`  out  1  registered overflow / divide-by-zero flag; valid with `data_result`
- `data_resultRDY`  out  1  high for exactly one cycle when a result completes
- `busy`  out  1  high while an operation is in flight (states MUL, DIV, FIX)

## Operation
- States:
  - IDLE: reset state.
  - MUL, DIV: 32 iterations each.
  - FIX: sign correction and result capture.
  - DONE: one cycle, asserts RDY, otherwise behaves as IDLE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE. Starts in MUL, DIV or FIX are ignored.
  - If `ctrl_MULT` and `ctrl_DIV` are high together, the multiply wins.
- On an accepted start:
  - Latch the magnitudes |A| and |B| and the signs sA, sB.
  - Clear the 6-bit iteration counter.
  - Go to MUL or DIV.
  - Exception: if DIV is started with B == 0, go directly to DONE with result 0 and exception 1. No iterations run.
- MUL datapath:
  - 64-bit product register, low half initialised to |B|, high half to 0.
  - Per iteration: if product[0] is set, add |A| into product[63:32] with carry into a 65th bit. Then shift right by 1.
- DIV datapath:
  - 64-bit {remainder, quotient} register, initialised to {0, |A|}.
  - Per iteration: shift left by 1, then trial-subtract |B| from the upper 33 bits.
  - If the trial result is non-negative, keep it and set quotient bit 0. Otherwise restore.
- Counter and FIX:
  - The counter increments each iteration. After iteration 32 (counter == 31 at the edge), go to FIX.
- FIX for MUL:
  - Negate the 64-bit magnitude product if sA ^ sB.
  - `data_result` = product[31:0].
  - `data_exception` = 1 if product[63:31] are not all equal, i.e. the product does not fit 32-bit signed.
  - A zero product with mixed signs is not an exception.
- FIX for DIV:
  - Quotient truncates toward zero; negate it if sA ^ sB. The remainder is discarded.
  - `data_result` = the 32-bit quotient.
  - `data_exception` = 1 only for 0x80000000 / 0xFFFFFFFF. The result in that case is 0x80000000.
- FIX always goes to DONE. DONE goes to IDLE, or to MUL/DIV if a new start is accepted that cycle.
- Reset (`reset_n` low, any time, including mid-operation):
  - State returns to IDLE and the operation is aborted.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0, counter = 0.

## Timing
- Start sampled at edge E0.
  - Iterations occur on edges E1..E32.
  - FIX captures the result at E33.
  - `data_resultRDY` is high in the cycle after E33.
- Latency: 33 cycles from the sampling edge to the RDY-high cycle, for both MUL and DIV.
- Divide by zero: RDY is high in the cycle after E0 (latency 1).
- `busy` rises in the cycle after E0 and falls in the same cycle RDY rises.
  - `busy` is never high together with `data_resultRDY`.
- `data_result` and `data_exception` change only on the FIX edge or the divide-by-zero edge. They remain stable through DONE and beyond.
- Back-to-back operation:
  - A start sampled during the DONE cycle is accepted, and RDY still pulses for the finishing op.
  - Sustained throughput is one op per 34 cycles.
- Operand inputs may change freely after E0.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) → `data_result` 0xFFFFFFEB, exception 0, RDY exactly 33 cycles after the start edge, `busy` high for 33 cycles.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x80000000 × 1 → 0x80000000, exception 0. MULT 0 × 0x80000000 → 0, exception 0.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3), exception 0. DIV 100 / 0xFFFFFFF6 (−10) → 0xFFFFFFF6, exception 0, 33-cycle latency.
- DIV 5 / 0 → result 0, exception 1, RDY the cycle after the start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, exception 1.
- Start behaviour:
  - `ctrl_DIV` pulsed at iteration 10 of a MULT 3 × 4 → ignored, result 12.
  - `ctrl_MULT` and `ctrl_DIV` together with A = 6, B = 3 → result 18.
  - A new start during DONE → accepted, with the second RDY 34 cycles after the first.
- `reset_n` low at iteration 20 of a DIV → all outputs 0 immediately, no RDY. After release, MULT 2 × 3 → 6, with normal latency.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage handshake bundle for the iterative multiply/divide unit.
// The master drives start pulses and operands; the slave (the unit) returns results.
interface multdiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) unit.
// Works on operand magnitudes for WIDTH iterations, then applies the sign in a FIX cycle.
module multdiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic           clock,
  input logic           reset_n,
  multdiv_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [5:0]           cnt_r;
  logic                 op_div_r;
  logic                 neg_r;
  logic [WIDTH-1:0]     mag_a_r;
  logic [WIDTH-1:0]     mag_b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     result_r;
  logic                 exc_r;
  logic                 rdy_r;
  logic                 busy_r;

  logic                 start_mul_s;
  logic                 start_div_s;
  logic                 div_zero_s;
  logic                 last_iter_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   prod_signed_s;
  logic [WIDTH-1:0]     quot_signed_s;
  logic [WIDTH-1:0]     fix_result_s;
  logic                 fix_exc_s;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1]) begin
      m = -v;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Start decode: only IDLE/DONE accept, multiply has priority over divide.
  always_comb begin
    start_mul_s = 1'b0;
    start_div_s = 1'b0;
    div_zero_s  = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      start_mul_s = bus.ctrl_MULT;
      start_div_s = ~bus.ctrl_MULT & bus.ctrl_DIV;
      div_zero_s  = start_div_s & (bus.data_operandB == {WIDTH{1'b0}});
    end else begin
      start_mul_s = 1'b0;
      start_div_s = 1'b0;
      div_zero_s  = 1'b0;
    end
  end

  assign last_iter_s = (cnt_r == 6'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_mul_s) begin
          state_next_s = ST_MUL;
        end else if (div_zero_s) begin
          state_next_s = ST_DONE;
        end else if (start_div_s) begin
          state_next_s = ST_DIV;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (last_iter_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_DIV: begin
        if (last_iter_s) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_DIV;
        end
      end
      ST_FIX:  state_next_s = ST_DONE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // One iteration of each algorithm; the divide shift is folded into the slice indices.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    div_next_s  = {acc_r[2*WIDTH-2:0], 1'b0};
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_trial_s = {1'b0, acc_r[2*WIDTH-2:WIDTH-1]} - {1'b0, mag_b_r};
    if (!div_trial_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and exception detection for the FIX cycle.
  always_comb begin
    prod_signed_s = neg_r ? -acc_r : acc_r;
    quot_signed_s = neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    fix_result_s  = {WIDTH{1'b0}};
    fix_exc_s     = 1'b0;
    if (op_div_r) begin
      fix_result_s = quot_signed_s;
      // A positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1.
      fix_exc_s    = acc_r[WIDTH-1] & ~neg_r;
    end else begin
      fix_result_s = prod_signed_s[WIDTH-1:0];
      fix_exc_s    = ~((&prod_signed_s[2*WIDTH-1:WIDTH-1]) |
                       ~(|prod_signed_s[2*WIDTH-1:WIDTH-1]));
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, iteration counter and working register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= 6'd0;
      op_div_r <= 1'b0;
      neg_r    <= 1'b0;
      mag_a_r  <= {WIDTH{1'b0}};
      mag_b_r  <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (start_mul_s || start_div_s) begin
      cnt_r    <= 6'd0;
      op_div_r <= start_div_s;
      neg_r    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      mag_a_r  <= magnitude(bus.data_operandA);
      mag_b_r  <= magnitude(bus.data_operandB);
      acc_r    <= start_mul_s ? {{WIDTH{1'b0}}, magnitude(bus.data_operandB)}
                              : {{WIDTH{1'b0}}, magnitude(bus.data_operandA)};
    end else if (state_r == ST_MUL) begin
      cnt_r <= cnt_r + 6'd1;
      acc_r <= mul_next_s;
    end else if (state_r == ST_DIV) begin
      cnt_r <= cnt_r + 6'd1;
      acc_r <= div_next_s;
    end
  end

  // Registered outputs; RDY and busy are decoded from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_r <= {WIDTH{1'b0}};
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      rdy_r  <= (state_next_s == ST_DONE);
      busy_r <= (state_next_s == ST_MUL) || (state_next_s == ST_DIV) ||
                (state_next_s == ST_FIX);
      if (state_r == ST_FIX) begin
        result_r <= fix_result_s;
        exc_r    <= fix_exc_s;
      end else if (div_zero_s) begin
        result_r <= {WIDTH{1'b0}};
        exc_r    <= 1'b1;
      end
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_exception = exc_r;
  assign bus.data_resultRDY = rdy_r;
  assign bus.busy           = busy_r;

endmodule
